// File: rtl/multi_read_fifo.sv
// Single-write, multi-read FIFO with all-or-nothing lane grants and optional reset preload.
// Optional feature: define MULTI_READ_FIFO_ERR_EN to add the sticky dropped-write flag 'err'.
module multi_read_fifo #(
    parameter int DATA_WIDTH               = 32,
    parameter int ADDR_WIDTH               = 4,
    parameter int MAX_NUM_OF_READS_WIDTH   = 1,
    parameter int MAX_NUM_OF_READS         = 1 << MAX_NUM_OF_READS_WIDTH,
    parameter bit RESET_INITIAL_PUSH_EN    = 1'b1,
    parameter int RESET_INITIAL_PUSH_START = 0,
    parameter int RESET_INITIAL_PUSH_COUNT = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        full,
    input  logic [MAX_NUM_OF_READS-1:0] rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data [MAX_NUM_OF_READS],
    output logic [MAX_NUM_OF_READS-1:0] rd_valid,
    output logic                        rd_grant,
    output logic                        empty,
    output logic                        next_empty,
`ifdef MULTI_READ_FIFO_ERR_EN
    output logic                        err,
`endif
    output logic [ADDR_WIDTH:0]         count
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int PRELOAD = RESET_INITIAL_PUSH_EN ? RESET_INITIAL_PUSH_COUNT : 0;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic [ADDR_WIDTH:0]   off_s [MAX_NUM_OF_READS];
    logic [ADDR_WIDTH:0]   num_reads_s;
    logic [ADDR_WIDTH:0]   reads_taken_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  grant_s;
    logic                  wr_acc_s;

    // Lane compaction: each lane reads the entry at head plus the number of requesting lanes below it.
    always_comb begin
        num_reads_s = '0;
        idx_s       = '0;
        rd_valid    = '0;
        for (int i = 0; i < MAX_NUM_OF_READS; i++) begin
            off_s[i]    = num_reads_s;
            num_reads_s = num_reads_s + (ADDR_WIDTH + 1)'(rd_en[i]);
        end
        for (int i = 0; i < MAX_NUM_OF_READS; i++) begin
            idx_s       = rd_ptr_q + off_s[i][ADDR_WIDTH-1:0];
            rd_data[i]  = mem_q[idx_s];
            rd_valid[i] = (off_s[i] < fill_q);
        end
    end

    // Grant, write acceptance and next-state pointer/count arithmetic.
    always_comb begin
        grant_s       = (num_reads_s <= fill_q);
        reads_taken_s = grant_s ? num_reads_s : '0;
        // A full FIFO still accepts a push when the same cycle frees a slot.
        wr_acc_s      = wr_en && ((fill_q - reads_taken_s) < DEPTH_C);
        wr_ptr_d      = wr_ptr_q + ADDR_WIDTH'(wr_acc_s);
        rd_ptr_d      = rd_ptr_q + reads_taken_s[ADDR_WIDTH-1:0];
        fill_d        = fill_q + (ADDR_WIDTH + 1)'(wr_acc_s) - reads_taken_s;
    end

    // Storage, pointers and fill count; reset restores the preload image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i < PRELOAD) ? DATA_WIDTH'(RESET_INITIAL_PUSH_START + i) : '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= ADDR_WIDTH'(PRELOAD % DEPTH);
            fill_q   <= (ADDR_WIDTH + 1)'(PRELOAD);
        end else begin
            if (wr_acc_s) begin
                mem_q[wr_ptr_q] <= wr_data;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

`ifdef MULTI_READ_FIFO_ERR_EN
    logic err_q;

    // Sticky flag raised by any push that was refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (wr_en && !wr_acc_s) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign err = err_q;
`endif

    assign rd_grant   = grant_s;
    assign empty      = (fill_q == '0);
    assign full       = (fill_q == DEPTH_C);
    assign next_empty = (fill_d == '0);
    assign count      = fill_q;

endmodule

// File: tb/tb_multi_read_fifo.sv
// Scoreboard bench for multi_read_fifo: a queue-based reference model predicts each cycle's outputs.
module tb_multi_read_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic [1:0]  rd_en = 2'b00;
    logic        full, empty, next_empty, rd_grant;
    logic [1:0]  rd_valid;
    logic [31:0] rd_data [2];
    logic [4:0]  count;
    logic        err;

    multi_read_fifo #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .MAX_NUM_OF_READS_WIDTH(1),
        .RESET_INITIAL_PUSH_EN(1'b1),
        .RESET_INITIAL_PUSH_START(32),
        .RESET_INITIAL_PUSH_COUNT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_grant(rd_grant),
        .empty(empty),
        .next_empty(next_empty),
`ifdef MULTI_READ_FIFO_ERR_EN
        .err(err),
`endif
        .count(count)
    );

`ifndef MULTI_READ_FIFO_ERR_EN
    initial err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rd;
        logic [4:0]  cnt;
        logic        empty;
        logic        full;
        logic        grant;
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        next_empty;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model_q [$];
    logic        err_m = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction on each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("count", 32'(count), 32'(e.cnt));
            check("empty", 32'(empty), 32'(e.empty));
            check("full", 32'(full), 32'(e.full));
            check("rd_grant", 32'(rd_grant), 32'(e.grant));
            check("rd_valid", 32'(rd_valid), 32'(e.valid));
            check("next_empty", 32'(next_empty), 32'(e.next_empty));
            if (e.rd[0] && e.valid[0]) check("rd_data0", rd_data[0], e.d0);
            if (e.rd[1] && e.valid[1]) check("rd_data1", rd_data[1], e.d1);
`ifdef MULTI_READ_FIFO_ERR_EN
            check("err", 32'(err), 32'(e.err));
`endif
        end
    end

    // Drive one cycle of stimulus and predict its outputs from the queue model.
    task automatic step(input logic w, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        int   sz, n, off1, taken;
        logic acc;
        @(posedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        sz      = model_q.size();
        n       = int'(r[0]) + int'(r[1]);
        off1    = int'(r[0]);
        e.rd    = r;
        e.cnt   = 5'(sz);
        e.empty = (sz == 0);
        e.full  = (sz == 16);
        e.grant = (n <= sz);
        e.valid = {(off1 < sz), (sz > 0)};
        e.d0    = (sz > 0) ? model_q[0] : 32'd0;
        e.d1    = (off1 < sz) ? model_q[off1] : 32'd0;
        e.err   = err_m;
        taken   = e.grant ? n : 0;
        acc     = w && ((sz - taken) < 16);
        for (int i = 0; i < taken; i++) void'(model_q.pop_front());
        if (acc) model_q.push_back(d);
        if (w && !acc) err_m = 1'b1;
        e.next_empty = (model_q.size() == 0);
        exp_q.push_back(e);
    endtask

    task automatic load_preload();
        model_q.delete();
        for (int i = 0; i < 8; i++) model_q.push_back(32'(32 + i));
        err_m = 1'b0;
    endtask

    initial begin
        // Reset state observed while reset is held, all lanes requesting.
        rd_en = 2'b11;
        #12;
        check("rst_count", 32'(count), 32'd8);
        check("rst_empty", 32'(empty), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_grant", 32'(rd_grant), 32'd1);
        check("rst_valid", 32'(rd_valid), 32'd3);
        check("rst_data0", rd_data[0], 32'd32);
        check("rst_data1", rd_data[1], 32'd33);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_en = 2'b00;
        load_preload();

        step(1'b0, 32'd0, 2'b11);
        step(1'b0, 32'd0, 2'b10);
        step(1'b0, 32'd0, 2'b11);
        step(1'b0, 32'd0, 2'b11);
        step(1'b0, 32'd0, 2'b11);   // count 1: denied
        step(1'b0, 32'd0, 2'b01);   // drains the last entry
        step(1'b1, 32'hAB, 2'b01);  // push into empty, no bypass
        step(1'b0, 32'd0, 2'b01);

        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 2'b00);
        step(1'b1, $urandom, 2'b01);   // full, accepted alongside a read
        step(1'b1, $urandom, 2'b00);   // full, dropped
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 2'b11);

        for (int i = 0; i < 120; i++) begin
            step(($urandom % 4) != 0, $urandom, 2'($urandom % 4));
        end

        // Mid-operation reset restores the preload image.
        step(1'b1, 32'h5555, 2'b00);
        @(negedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 2'b11;
        #1;
        check("midrst_count", 32'(count), 32'd8);
        check("midrst_data0", rd_data[0], 32'd32);
        @(negedge clk);
        reset = 1'b0;
        rd_en = 2'b00;
        load_preload();
        step(1'b0, 32'd0, 2'b11);
        step(1'b0, 32'd0, 2'b01);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_read_fifo.md
Name: multi_read_fifo

Overview:
Synchronous FIFO with one write port and up to MAX_NUM_OF_READS pops per cycle. It is the consumer-side counterpart of the multi-write FIFO. In the rename stage it is the physical-register allocator: committed registers are pushed one at a time, and several rename lanes pop free tags in the same cycle. Reads are all-or-nothing: either every requesting lane is granted, or none is.

Parameters:
DATA_WIDTH, 32, entry width.
ADDR_WIDTH, 4, log2 of depth; DEPTH = 1<<ADDR_WIDTH.
MAX_NUM_OF_READS_WIDTH, 1, log2 of number of read lanes.
MAX_NUM_OF_READS, 1<<MAX_NUM_OF_READS_WIDTH, number of read lanes; must be <= DEPTH.
RESET_INITIAL_PUSH_EN, 1, preload the FIFO on reset.
RESET_INITIAL_PUSH_START, 0, first preload value.
RESET_INITIAL_PUSH_COUNT, 0, number of preloaded entries (<= DEPTH).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  push request.
wr_data  in  DATA_WIDTH  push data.
full  out  1  fill_count == DEPTH.
rd_en  in  MAX_NUM_OF_READS  per-lane pop request; any bit pattern is legal.
rd_data  out  DATA_WIDTH x MAX_NUM_OF_READS  per-lane head data (unpacked array).
rd_valid  out  MAX_NUM_OF_READS  lane i can be served this cycle.
rd_grant  out  1  all requested lanes are served this cycle.
empty  out  1  fill_count == 0.
next_empty  out  1  fill_count_next == 0.
count  out  ADDR_WIDTH+1  current fill count.

Behaviour:
- State: memory[DEPTH], rd_ptr, wr_ptr (ADDR_WIDTH bits, natural wrap modulo DEPTH), fill_count (ADDR_WIDTH+1 bits).
- Reset (async): rd_ptr = 0, fill_count = 0, wr_ptr = 0.
  - If RESET_INITIAL_PUSH_EN: memory[i] = START+i for i < COUNT; wr_ptr = COUNT mod DEPTH; fill_count = COUNT.
  - Resulting outputs: empty = (COUNT==0); full = (COUNT==DEPTH); rd_grant follows rd_en combinationally.
  - Reset mid-operation discards all contents and restores the preload.
- Lane compaction: off(i) = number of set rd_en bits below i.
  - rd_data[i] = memory[rd_ptr + off(i)], mod DEPTH.
  - rd_valid[i] = (off(i) < fill_count).
  - Lanes with rd_en[i]=0 still present data; that data is don't-care.
- num_reads = popcount(rd_en).
- rd_grant = (num_reads <= fill_count). rd_grant is 1 when rd_en == 0.
- Reads taken = rd_grant ? num_reads : 0. Reads are combinational, zero latency: data is valid in the same cycle as the grant.
- Denied request: no pointer or count change. The requester holds rd_en and retries.
- Write accepted (wr_acc) = wr_en && (fill_count - reads_taken < DEPTH). A write into a full FIFO is accepted when at least one read is taken that cycle.
- A dropped write leaves memory, wr_ptr and fill_count unchanged.
- On a clock edge:
  - memory[wr_ptr] <= wr_data if wr_acc.
  - wr_ptr += wr_acc.
  - rd_ptr += reads_taken.
  - fill_count_next = fill_count + wr_acc - reads_taken.
- No write-to-read bypass: data pushed in cycle N is readable from cycle N+1. A push into an empty FIFO cannot satisfy a read in the same cycle.
- Order is strictly FIFO across pointer wrap-around.

Optional Feature:
MULTI_READ_FIFO_ERR_EN.
- Defined: adds output port err (1 bit). err is sticky; it sets on the clock edge after a dropped write (wr_en && !wr_acc). It is cleared only by reset, which drives it to 0.
- Undefined: the port is absent and dropped writes are silent. All other behaviour is identical in both builds.

Test Plan:
1. Reset with DEPTH=16, READS=2, PUSH_COUNT=8, START=32 -> count=8, empty=0, full=0, rd_data[0]=32, rd_data[1]=33, rd_valid=2'b11.
2. rd_en=2'b11 for one cycle -> rd_grant=1 with data 32/33 in that cycle. Next cycle: rd_data[0]=34, count=6.
3. rd_en=2'b10 with head=34 -> rd_data[1]=34, rd_grant=1. Next cycle: head=35, count=5.
4. count=1 (head=X), rd_en=2'b11 -> rd_grant=0, rd_valid=2'b01. Next cycle: count=1, head still X. Separately, push 0xAB into an empty FIFO with rd_en=01 -> rd_grant=0; next cycle count=1, rd_data[0]=0xAB.
5. Fill to 16, then wr_en=1 with rd_en=2'b01 -> write accepted, count stays 16. Then wr_en=1 with rd_en=0 -> dropped, count=16, contents unchanged; with the macro, err=1 from the next cycle until reset.
6. 40 cycles of random push/pop with PUSH_COUNT=0 -> popped sequence matches the pushed sequence across at least two pointer wraps; count never exceeds 16; next_empty matches the following cycle's empty.
